// File: rtl/immgen_pkg.sv
// -----------------------------------------------------------------------------
// immgen_pkg
//   Shared constants for the decode-stage immediate generator: immediate type
//   codes, the RV base opcodes the auto-decoder recognises, and the XLEN
//   legality check used at elaboration.
//   No ports (package).
// -----------------------------------------------------------------------------
package immgen_pkg;

   // Immediate type codes (3 bits, carried on imm_type)
   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_U     = 3'b011;
   localparam logic [2:0] IMM_J     = 3'b100;
   localparam logic [2:0] IMM_SHAMT = 3'b101;
   localparam logic [2:0] IMM_ZIMM  = 3'b110;
   localparam logic [2:0] IMM_NONE  = 3'b111;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Only RV32 and RV64 datapaths are supported.
   function automatic bit xlen_ok(int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

endpackage

// File: rtl/immgen_pipe_if.sv
// -----------------------------------------------------------------------------
// immgen_pipe_if
//   Valid/ready bundle around the immediate generator.
//   Input side : in_valid, in_ready, instr[31:0], imm_sel[2:0]
//   Output side: out_valid, out_ready, imm[XLEN-1:0], imm_type[2:0], illegal
//   master = the fetch/decode environment, slave = immgen_pipe.
// -----------------------------------------------------------------------------
interface immgen_pipe_if #(parameter int XLEN = 32);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [2:0]      imm_sel;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
   logic [2:0]      imm_type;
   logic            illegal;

   modport master (
      output in_valid, instr, imm_sel, out_ready,
      input  in_ready, out_valid, imm, imm_type, illegal
   );

   modport slave (
      input  in_valid, instr, imm_sel, out_ready,
      output in_ready, out_valid, imm, imm_type, illegal
   );

endinterface

// File: rtl/immgen_pipe_imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract (combinational)
//   Resolves the immediate type (opcode decode or external select) and builds
//   the sign/zero-extended XLEN-wide immediate for that type.
//   instr[31:0]    in   instruction word
//   imm_sel[2:0]   in   type select, used only when AUTO_DECODE=0
//   imm[XLEN-1:0]  out  extended immediate (0 when illegal)
//   imm_type[2:0]  out  resolved type code
//   illegal        out  no immediate format applies
// -----------------------------------------------------------------------------
module imm_extract
   import immgen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit AUTO_DECODE = 1'b1
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_sel,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            illegal
);

   logic [2:0] dec_type;
   logic [2:0] funct3;

   assign funct3 = instr[14:12];

   // NOTE: every always_comb output gets a default first so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      dec_type = IMM_NONE;
      case (instr[6:0])
         OP_IMM:             dec_type = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
         OP_LOAD, OP_JALR:   dec_type = IMM_I;
         OP_SYSTEM:          dec_type = funct3[2] ? IMM_ZIMM : IMM_I;
         OP_STORE:           dec_type = IMM_S;
         OP_BRANCH:          dec_type = IMM_B;
         OP_LUI, OP_AUIPC:   dec_type = IMM_U;
         OP_JAL:             dec_type = IMM_J;
         default:            dec_type = IMM_NONE;
      endcase
   end

   assign imm_type = AUTO_DECODE ? dec_type : imm_sel;

   // Sized casts of signed operands sign-extend to XLEN; unsigned ones zero-extend.
   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (imm_type)
         IMM_I:     imm = XLEN'($signed(instr[31:20]));
         IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         IMM_SHAMT: begin
            // RV32 shift amounts are 5 bits; instr[25] is ignored there, not trapped.
            if (XLEN == 64) imm = XLEN'(instr[25:20]);
            else            imm = XLEN'(instr[24:20]);
         end
         IMM_ZIMM:  imm = XLEN'(instr[19:15]);
         default:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/immgen_pipe.sv
// -----------------------------------------------------------------------------
// immgen_pipe (top)
//   Registered immediate generator with a valid/ready handshake on both sides.
//   One output register (O) plus one skid register (K) give one beat per
//   cycle under backpressure with in_ready driven straight from a flop.
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   flush   in   discard every held beat and the beat accepted this cycle
//   bus     slave modport of immgen_pipe_if (in_*, instr, imm_sel, out_*,
//                imm, imm_type, illegal)
// -----------------------------------------------------------------------------
module immgen_pipe
   import immgen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit AUTO_DECODE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   immgen_pipe_if.slave bus
);

   if (!xlen_ok(XLEN)) begin : g_bad_xlen
      $error("immgen_pipe: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      imm_type;
      logic            illegal;
   } beat_t;

   logic [XLEN-1:0] x_imm;
   logic [2:0]      x_type;
   logic            x_illegal;
   beat_t           in_beat;
   beat_t           o_q;
   beat_t           k_q;
   logic            o_valid_q;
   logic            k_valid_q;
   logic            accept;
   logic            o_free;
   logic            load_k;

   imm_extract #(
      .XLEN        (XLEN),
      .AUTO_DECODE (AUTO_DECODE)
   ) u_extract (
      .instr    (bus.instr),
      .imm_sel  (bus.imm_sel),
      .imm      (x_imm),
      .imm_type (x_type),
      .illegal  (x_illegal)
   );

   assign in_beat = '{imm: x_imm, imm_type: x_type, illegal: x_illegal};

   // K can only fill while O is stalled, so an empty K means room for one beat.
   assign accept = bus.in_valid && !k_valid_q;
   assign o_free = !o_valid_q || bus.out_ready;
   assign load_k = rst_n && !flush && !o_free && accept;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_valid_q <= 1'b0;
         k_valid_q <= 1'b0;
         o_q       <= '{imm: '0, imm_type: IMM_NONE, illegal: 1'b0};
      end else if (flush) begin
         o_valid_q <= 1'b0;
         k_valid_q <= 1'b0;
      end else if (o_free) begin
         // Older beat in K always goes first to preserve order.
         if (k_valid_q) begin
            o_q       <= k_q;
            o_valid_q <= 1'b1;
            k_valid_q <= 1'b0;
         end else begin
            o_valid_q <= accept;
            if (accept) o_q <= in_beat;
         end
      end else if (accept) begin
         k_valid_q <= 1'b1;
      end
   end

   // NOTE: the skid payload is qualified by k_valid_q, so it needs no reset
   // and is kept out of the reset branch.
   always_ff @(posedge clk) begin
      if (load_k) k_q <= in_beat;
   end

   assign bus.in_ready  = !k_valid_q;
   assign bus.out_valid = o_valid_q;
   assign bus.imm       = o_q.imm;
   assign bus.imm_type  = o_q.imm_type;
   assign bus.illegal   = o_q.illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// -----------------------------------------------------------------------------
// tb_immgen_pipe
//   Three DUTs (RV32 auto-decode, RV64 auto-decode, RV32 external select)
//   share one stimulus stream. Accepted beats are pushed into per-DUT
//   expected queues from a reference model; a monitor pops and compares
//   whenever a DUT hands a beat to the consumer, and also checks occupancy
//   (out_valid / in_ready) and output stability while stalled.
// -----------------------------------------------------------------------------
module tb_immgen_pipe;
   import immgen_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] instr = '0;
   logic [2:0]  imm_sel = '0;
   logic        checking = 1'b0;

   always #5 clk = ~clk;

   immgen_pipe_if #(.XLEN(32)) bus_a ();
   immgen_pipe_if #(.XLEN(64)) bus_b ();
   immgen_pipe_if #(.XLEN(32)) bus_c ();

   assign bus_a.in_valid = in_valid;  assign bus_a.instr = instr;
   assign bus_a.imm_sel  = imm_sel;   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid = in_valid;  assign bus_b.instr = instr;
   assign bus_b.imm_sel  = imm_sel;   assign bus_b.out_ready = out_ready;
   assign bus_c.in_valid = in_valid;  assign bus_c.instr = instr;
   assign bus_c.imm_sel  = imm_sel;   assign bus_c.out_ready = out_ready;

   immgen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a));
   immgen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b));
   immgen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_c));

   logic        ov [3];
   logic        ir [3];
   logic        il [3];
   logic [63:0] im [3];
   logic [2:0]  ty [3];

   assign ov[0] = bus_a.out_valid;  assign ir[0] = bus_a.in_ready;  assign il[0] = bus_a.illegal;
   assign im[0] = 64'(bus_a.imm);   assign ty[0] = bus_a.imm_type;
   assign ov[1] = bus_b.out_valid;  assign ir[1] = bus_b.in_ready;  assign il[1] = bus_b.illegal;
   assign im[1] = bus_b.imm;        assign ty[1] = bus_b.imm_type;
   assign ov[2] = bus_c.out_valid;  assign ir[2] = bus_c.in_ready;  assign il[2] = bus_c.illegal;
   assign im[2] = 64'(bus_c.imm);   assign ty[2] = bus_c.imm_type;

   int tests = 0;
   int fails = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [63:0] imm;
      logic [2:0]  typ;
      logic        ill;
   } exp_t;

   function automatic int xlen_of(int k);
      return (k == 1) ? 64 : 32;
   endfunction

   function automatic bit auto_of(int k);
      return (k != 2);
   endfunction

   function automatic logic [2:0] spec_type(logic [31:0] ins);
      logic [6:0] op;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      if (op == 7'h13)                    return (f3 == 3'd1 || f3 == 3'd5) ? IMM_SHAMT : IMM_I;
      if (op == 7'h03 || op == 7'h67)     return IMM_I;
      if (op == 7'h73)                    return f3[2] ? IMM_ZIMM : IMM_I;
      if (op == 7'h23)                    return IMM_S;
      if (op == 7'h63)                    return IMM_B;
      if (op == 7'h37 || op == 7'h17)     return IMM_U;
      if (op == 7'h6F)                    return IMM_J;
      return IMM_NONE;
   endfunction

   // Arithmetic formulation: sx is the instruction as a signed 64-bit number,
   // so arithmetic right shifts of sx give sign-extended upper fields.
   function automatic exp_t ref_model(int k, logic [31:0] ins, logic [2:0] sel);
      exp_t   e;
      longint sx;
      longint v;
      logic [2:0] t;
      t     = auto_of(k) ? spec_type(ins) : sel;
      sx    = longint'($signed(ins));
      v     = 0;
      e.ill = 1'b0;
      case (t)
         IMM_I:     v = sx >>> 20;
         IMM_S:     v = ((sx >>> 25) <<< 5) | longint'(ins[11:7]);
         IMM_B:     v = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                        | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         IMM_U:     v = (sx >>> 12) <<< 12;
         IMM_J:     v = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                        | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         IMM_SHAMT: v = (xlen_of(k) == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
         IMM_ZIMM:  v = longint'(ins[19:15]);
         default:   begin v = 0; e.ill = 1'b1; end
      endcase
      e.imm = (xlen_of(k) == 32) ? 64'(v[31:0]) : 64'(v);
      e.typ = t;
      return e;
   endfunction

   // ---------------- scoreboard input side ----------------
   exp_t sb [3][$];
   logic cap_acc [3];
   exp_t cap_e [3];
   logic cap_fl = 1'b0;
   logic cap_rs = 1'b0;

   always @(negedge clk) begin
      cap_fl = flush;
      cap_rs = rst_n;
      for (int k = 0; k < 3; k++) begin
         cap_acc[k] = in_valid && ir[k];
         cap_e[k]   = ref_model(k, instr, imm_sel);
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!cap_rs || cap_fl) sb[k].delete();
         else if (cap_acc[k] === 1'b1) sb[k].push_back(cap_e[k]);
      end
   end

   // ---------------- monitor ----------------
   logic        prev_stall [3] = '{1'b0, 1'b0, 1'b0};
   logic [63:0] prev_imm [3];
   logic [2:0]  prev_ty [3];
   logic        prev_il [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (checking && rst_n) begin
            check($sformatf("occ_out_valid_%0d", k), 64'(ov[k]), 64'(sb[k].size() > 0));
            check($sformatf("occ_in_ready_%0d", k),  64'(ir[k]), 64'(sb[k].size() < 2));
            if (prev_stall[k]) begin
               check($sformatf("hold_imm_%0d", k),  im[k], prev_imm[k]);
               check($sformatf("hold_type_%0d", k), 64'(ty[k]), 64'(prev_ty[k]));
               check($sformatf("hold_ill_%0d", k),  64'(il[k]), 64'(prev_il[k]));
            end
            if (ov[k] && out_ready && !flush && sb[k].size() > 0) begin
               exp_t e;
               e = sb[k].pop_front();
               check($sformatf("beat_imm_%0d", k),  im[k], e.imm);
               check($sformatf("beat_type_%0d", k), 64'(ty[k]), 64'(e.typ));
               check($sformatf("beat_ill_%0d", k),  64'(il[k]), 64'(e.ill));
            end
         end
         prev_stall[k] = checking && rst_n && !flush && ov[k] && !out_ready;
         prev_imm[k]   = im[k];
         prev_ty[k]    = ty[k];
         prev_il[k]    = il[k];
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(string tag);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_out_valid_%0d", tag, k), 64'(ov[k]), 64'd0);
         check($sformatf("%s_imm_%0d", tag, k),       im[k],      64'd0);
         check($sformatf("%s_type_%0d", tag, k),      64'(ty[k]), 64'(IMM_NONE));
         check($sformatf("%s_ill_%0d", tag, k),       64'(il[k]), 64'd0);
         check($sformatf("%s_in_ready_%0d", tag, k),  64'(ir[k]), 64'd1);
      end
   endtask

   // Single beat through an empty pipe; result must appear one cycle later.
   task automatic kat(string name, int k, logic [31:0] ins, logic [2:0] sel,
                      logic [63:0] e_imm, logic [2:0] e_ty, logic e_il);
      instr     = ins;
      imm_sel   = sel;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, 64'(ov[k]), 64'd1);
      check({name, "_imm"},   im[k], e_imm);
      check({name, "_type"},  64'(ty[k]), 64'(e_ty));
      check({name, "_ill"},   64'(il[k]), 64'(e_il));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  ops [11];
      ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33};
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 10)];
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      step();
      step();
      reset_checks("por");
      rst_n    = 1'b1;
      checking = 1'b1;
      step();

      // Known answers
      kat("addi_m1_32",   0, 32'hFFF00093, 3'd0,      64'hFFFF_FFFF,           IMM_I,     1'b0);
      kat("addi_m1_64",   1, 32'hFFF00093, 3'd0,      64'hFFFF_FFFF_FFFF_FFFF, IMM_I,     1'b0);
      kat("beq_m4_32",    0, 32'hFE000EE3, 3'd0,      64'hFFFF_FFFC,           IMM_B,     1'b0);
      kat("bad_op_32",    0, 32'h0000007F, 3'd0,      64'd0,                   IMM_NONE,  1'b1);
      kat("lui_64",       1, 32'h800000B7, 3'd0,      64'hFFFF_FFFF_8000_0000, IMM_U,     1'b0);
      kat("slli33_64",    1, 32'h02109093, 3'd0,      64'd33,                  IMM_SHAMT, 1'b0);
      kat("slli_b25_32",  0, 32'h02109093, 3'd0,      64'd1,                   IMM_SHAMT, 1'b0);
      kat("zimm_sel",     2, 32'h000F8000, IMM_ZIMM,  64'd31,                  IMM_ZIMM,  1'b0);
      kat("none_sel",     2, 32'hFFFFFFFF, IMM_NONE,  64'd0,                   IMM_NONE,  1'b1);
      kat("jal_sel",      2, 32'h8000006F, IMM_J,     64'hFFF0_0000,           IMM_J,     1'b0);

      // Backpressure: A,B,C back-to-back with the consumer stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h00100093;   // A: addi 1
      step();
      instr     = 32'h00200093;   // B: addi 2
      step();
      instr     = 32'h00300093;   // C: addi 3
      @(negedge clk);
      check("bp_ready_low_after_b", 64'(ir[0]), 64'd0);
      step();
      step();
      @(negedge clk);
      check("bp_ready_still_low", 64'(ir[0]), 64'd0);
      check("bp_out_held",        64'(ov[0]), 64'd1);
      out_ready = 1'b1;
      check("bp_release_a", 64'(ov[0]), 64'd1);
      for (int i = 0; i < 2; i++) begin
         logic acc;
         acc = in_valid && ir[0];
         step();
         if (acc) in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("bp_no_gap_%0d", i), 64'(ov[0]), 64'd1);
      end
      check("bp_c_accepted", 64'(in_valid), 64'd0);
      in_valid = 1'b0;
      repeat (3) step();

      // Flush with O and K full and a beat offered in the flush cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h00500113;
      step();
      step();
      @(negedge clk);
      check("fl_k_full", 64'(ir[0]), 64'd0);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("fl_out_valid_%0d", k), 64'(ov[k]), 64'd0);
         check($sformatf("fl_in_ready_%0d", k),  64'(ir[k]), 64'd1);
      end
      out_ready = 1'b1;
      step();

      // Reset mid-stream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h123450B7;
      step();
      step();
      rst_n = 1'b0;
      step();
      reset_checks("mid_rst");
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         instr     = rand_instr();
         imm_sel   = 3'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         rst_n     = ($urandom_range(0, 299) != 0);
         step();
      end

      // Drain and confirm nothing was lost
      in_valid  = 1'b0;
      flush     = 1'b0;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (5) step();
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         check($sformatf("drain_empty_%0d", k), 64'(sb[k].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
